// File: rtl/fp_pkg.sv
// Shared FP32 format constants and IEEE-754 class encoding used across FPU stages.
package fp_pkg;

  localparam int unsigned FP32_DATA_W = 32;
  localparam int unsigned FP32_EXPO_W = 8;
  localparam int unsigned FP32_MANT_W = 23;

  localparam logic [FP32_EXPO_W-1:0] EXPO_ALL_ONES = '1;

  localparam int unsigned CLS_ZERO = 0;
  localparam int unsigned CLS_SUB  = 1;
  localparam int unsigned CLS_INF  = 2;
  localparam int unsigned CLS_NAN  = 3;

  // {nan, inf, sub, zero}; at most one bit set, all clear for a normal number
  typedef logic [3:0] fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 classifier: float in, one-hot-or-zero class out.
module fp_classify
  import fp_pkg::*;
#(
  parameter int unsigned DATA_W = FP32_DATA_W,
  parameter int unsigned EXPO_W = FP32_EXPO_W,
  parameter int unsigned MANT_W = FP32_MANT_W
) (
  input  logic [DATA_W-1:0] value,
  output fp_class_t         cls_c
);

  logic [EXPO_W-1:0] expo;
  logic [MANT_W-1:0] mant;
  logic              unused_sign;
  logic              expo_zero;
  logic              expo_ones;
  logic              mant_zero;

  assign expo        = value[MANT_W +: EXPO_W];
  assign mant        = value[MANT_W-1:0];
  assign unused_sign = value[DATA_W-1];

  always_comb begin
    cls_c     = '0;
    expo_zero = (expo == '0);
    expo_ones = &expo;
    mant_zero = (mant == '0);
    cls_c[CLS_ZERO] = expo_zero &  mant_zero;
    cls_c[CLS_SUB]  = expo_zero & ~mant_zero;
    cls_c[CLS_INF]  = expo_ones &  mant_zero;
    cls_c[CLS_NAN]  = expo_ones & ~mant_zero;
  end

endmodule

// File: rtl/fp_result_buf.sv
// FWFT result FIFO behind the FP32 scaler with almost-full hint and sticky overflow.
// Optional per-entry class flags when FP_RESULT_BUF_CLASSIFY_EN is defined.
module fp_result_buf
  import fp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned EXPO_WIDTH = 8,
  parameter int unsigned MANT_WIDTH = 23,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AFULL_LVL  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       vld_in,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       vld_out,
  input  logic                       rdy_in,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_err,
  input  logic                       clr_err,
  output fp_class_t                  class_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;

  logic             pop_c;
  logic             push_req_c;
  logic             push_c;
  logic             ovf_set_c;
  logic [CNT_W-1:0] count_nxt_c;

  // A full FIFO still accepts a push when the head leaves on the same edge
  always_comb begin
    pop_c       = vld_out & rdy_in & en;
    push_req_c  = vld_in & en;
    push_c      = push_req_c & ((count < CNT_W'(DEPTH)) | pop_c);
    ovf_set_c   = push_req_c & ~push_c;
    count_nxt_c = count;
    if (push_c && !pop_c) begin
      count_nxt_c = count + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_nxt_c = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      vld_out     <= 1'b0;
      almost_full <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_nxt_c;
      vld_out     <= (count_nxt_c != '0);
      almost_full <= (count_nxt_c >= CNT_W'(AFULL_LVL));
      if (ovf_set_c) begin
        ovf_err <= 1'b1;
      end else if (clr_err) begin
        ovf_err <= 1'b0;
      end
    end
  end

  // Storage is cleared on reset so an empty head reads as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_c) begin
      mem[wr_ptr] <= data_in;
    end
  end

  assign data_out = mem[rd_ptr];

`ifdef FP_RESULT_BUF_CLASSIFY_EN
  fp_class_t cls_mem [DEPTH];
  fp_class_t cls_in_c;

  fp_classify #(
    .DATA_W (DATA_WIDTH),
    .EXPO_W (EXPO_WIDTH),
    .MANT_W (MANT_WIDTH)
  ) u_classify (
    .value (data_in),
    .cls_c (cls_in_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) cls_mem[i] <= '0;
    end else if (push_c) begin
      cls_mem[wr_ptr] <= cls_in_c;
    end
  end

  assign class_out = cls_mem[rd_ptr];
`else
  localparam int unsigned unused_fmt_w = EXPO_WIDTH + MANT_WIDTH;

  assign class_out = '0;
`endif

endmodule

// File: tb/tb_fp_result_buf.sv
// Randomized and directed bench for fp_result_buf against a queue-based reference model.
module tb_fp_result_buf;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFULL = 3;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] data_in;
  logic        vld_in;
  logic [31:0] data_out;
  logic        vld_out;
  logic        rdy_in;
  logic        almost_full;
  logic [2:0]  count;
  logic        ovf_err;
  logic        clr_err;
  logic [3:0]  class_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q[$];
  logic        ovf_m;

  fp_result_buf #(
    .DATA_WIDTH (32),
    .EXPO_WIDTH (8),
    .MANT_WIDTH (23),
    .DEPTH      (DEPTH),
    .AFULL_LVL  (AFULL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .data_in     (data_in),
    .vld_in      (vld_in),
    .data_out    (data_out),
    .vld_out     (vld_out),
    .rdy_in      (rdy_in),
    .almost_full (almost_full),
    .count       (count),
    .ovf_err     (ovf_err),
    .clr_err     (clr_err),
    .class_out   (class_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Class of a float from its fields, sign ignored
  function automatic logic [3:0] ref_class(input logic [31:0] v);
    logic [7:0]  e;
    logic [22:0] m;
    e = v[30:23];
    m = v[22:0];
`ifdef FP_RESULT_BUF_CLASSIFY_EN
    if (e == 8'h00) return (m == 0) ? 4'b0001 : 4'b0010;
    if (e == 8'hFF) return (m == 0) ? 4'b0100 : 4'b1000;
`endif
    return 4'b0000;
  endfunction

  task automatic compare_all();
    check("count", 32'(count), 32'(q.size()));
    check("vld_out", 32'(vld_out), 32'(q.size() != 0));
    check("almost_full", 32'(almost_full), 32'(q.size() >= AFULL));
    check("ovf_err", 32'(ovf_err), 32'(ovf_m));
    if (q.size() != 0) begin
      check("data_out", data_out, q[0]);
      check("class_out", 32'(class_out), 32'(ref_class(q[0])));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_vld"}, 32'(vld_out), 32'd0);
    check({tag, "_afull"}, 32'(almost_full), 32'd0);
    check({tag, "_ovf"}, 32'(ovf_err), 32'd0);
    check({tag, "_data"}, data_out, 32'd0);
    check({tag, "_class"}, 32'(class_out), 32'd0);
  endtask

  // One clock: drive, let the edge happen, advance the model, then compare
  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      input logic e, input logic c);
    bit pop, preq, acc;
    vld_in  = v;
    data_in = d;
    rdy_in  = r;
    en      = e;
    clr_err = c;
    @(posedge clk);
    pop  = (q.size() != 0) && r && e;
    preq = v && e;
    acc  = preq && ((q.size() < DEPTH) || pop);
    if (preq && !acc) ovf_m = 1'b1;
    else if (c)       ovf_m = 1'b0;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(d);
    #1;
    compare_all();
  endtask

  task automatic idle(input logic r);
    step(1'b0, 32'h0, r, 1'b1, 1'b0);
  endtask

  logic [31:0] specials [8] = '{32'h7F800000, 32'h7FC00000, 32'h00000001, 32'h80000000,
                                32'h3F800000, 32'hFF800000, 32'h807FFFFF, 32'h00000000};

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    data_in = '0;
    vld_in  = 1'b0;
    rdy_in  = 1'b0;
    clr_err = 1'b0;
    ovf_m   = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single push with consumer ready
    step(1'b1, 32'h40490FDB, 1'b1, 1'b1, 1'b0);
    idle(1'b1);

    // five pushes into a stalled consumer, then drain
    for (int i = 0; i < 5; i++) step(1'b1, 32'h3F800000 + 32'(i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // full FIFO with simultaneous push and pop across the pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, 32'h41000000 + 32'(i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'h42000000 + 32'(i), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // special values through the classifier
    for (int i = 0; i < 5; i++) step(1'b1, specials[i], 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // overflow set beats a same-cycle clear, then clear alone
    for (int i = 0; i < 5; i++) step(1'b1, 32'h43000000 + 32'(i), 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h43100000, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // disabled stage freezes everything
    for (int i = 0; i < 3; i++) step(1'b1, 32'h44000000 + 32'(i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h45000000 + 32'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : 32'($urandom);
      step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0));
    end

    // asynchronous reset in the middle of a cycle
    for (int i = 0; i < 3; i++) step(1'b1, 32'h46000000 + 32'(i), 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h46100000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h46200000, 1'b0, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    q.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    step(1'b1, 32'hC0490FDB, 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
